// File: rtl/ahb_subordinate_regs_if.sv
// rtl/ahb_subordinate_regs_if.sv - AHB-Lite bus bundle between manager and register subordinate
interface ahb_subordinate_regs_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
);
    logic                    hsel;
    logic [ADDR_WIDTH-1:0]   haddr;
    logic [2:0]              hsize;
    logic [1:0]              htrans;
    logic [2:0]              hburst;
    logic                    hwrite;
    logic [DATA_WIDTH*8-1:0] hwdata;
    logic [DATA_WIDTH*8-1:0] hrdata;
    logic                    hresp;
    logic                    hready;

    modport master (
        output hsel, haddr, hsize, htrans, hburst, hwrite, hwdata,
        input  hrdata, hresp, hready
    );

    modport slave (
        input  hsel, haddr, hsize, htrans, hburst, hwrite, hwdata,
        output hrdata, hresp, hready
    );
endinterface

// File: rtl/ahb_subordinate_regs.sv
// rtl/ahb_subordinate_regs.sv - AHB-Lite subordinate register file with wait states and ERROR response
module ahb_subordinate_regs #(
    parameter int DATA_WIDTH  = 2,
    parameter int ADDR_WIDTH  = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    ahb_subordinate_regs_if.slave                          bus,
    input  logic [DATA_WIDTH*8-1:0]                        status_in,
    output logic [(2**ADDR_WIDTH)*8-2*DATA_WIDTH*8-1:0]    ctrl_out
);
    localparam int NUM_WORDS = (2**ADDR_WIDTH) / DATA_WIDTH;
    localparam int DW        = DATA_WIDTH * 8;
    localparam int LANE_BITS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 0;
    localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int RW_WORDS  = NUM_WORDS - 2;
    localparam logic [WIDX_W-1:0] RO_IDX  = WIDX_W'(NUM_WORDS - 2);
    localparam logic [WIDX_W-1:0] RSV_IDX = WIDX_W'(NUM_WORDS - 1);
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic [DW-1:0]         regs_q [RW_WORDS];
    logic [DW-1:0]         regs_d [RW_WORDS];

    logic                  hready_int;
    logic                  capture;
    logic                  req_err;
    logic [WIDX_W-1:0]     req_idx;
    logic [WIDX_W-1:0]     cur_idx;
    logic [31:0]           align_mask;
    logic [DW-1:0]         rdata;
    int                    lane_off;
    int                    nbytes;
    logic                  unused_bus;

    // Burst type and the SEQ/NSEQ distinction are irrelevant: every beat decodes on its own.
    assign unused_bus = ^{bus.hburst, bus.htrans[0]};

    assign hready_int = !(state_q == S_WAIT || state_q == S_ERR1);
    assign capture    = hready_int && bus.hsel && bus.htrans[1];
    assign cur_idx    = WIDX_W'(32'(addr_q) >> LANE_BITS);

    always_comb begin
        align_mask = (32'd1 << bus.hsize) - 32'd1;
        req_idx    = WIDX_W'(32'(bus.haddr) >> LANE_BITS);
        req_err    = (bus.hsize > 3'(LANE_BITS))
                   || (|(32'(bus.haddr) & align_mask))
                   || (bus.hwrite && (req_idx == RO_IDX))
                   || (req_idx == RSV_IDX);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        case (state_q)
            S_WAIT: begin
                if (wait_cnt_q == WS_LAST) begin
                    state_d = S_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        // Only reachable from IDLE, DATA or ERR2 since capture requires hready high.
        if (capture) begin
            addr_d     = bus.haddr;
            size_d     = bus.hsize;
            write_d    = bus.hwrite;
            wait_cnt_d = 4'd0;
            if (req_err) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
            end else begin
                state_d = S_DATA;
            end
        end
    end

    // DATA is only ever entered for a legal access, so cur_idx is a read/write word here.
    always_comb begin
        regs_d   = regs_q;
        lane_off = int'(32'(addr_q) & (DATA_WIDTH - 1));
        nbytes   = int'(32'd1 << size_q);
        if (state_q == S_DATA && write_q) begin
            for (int w = 0; w < RW_WORDS; w++) begin
                if (w == int'(cur_idx)) begin
                    for (int b = 0; b < DATA_WIDTH; b++) begin
                        if (b >= lane_off && b < lane_off + nbytes) begin
                            regs_d[w][b*8 +: 8] = bus.hwdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            size_q     <= 3'd0;
            write_q    <= 1'b0;
            for (int w = 0; w < RW_WORDS; w++) begin
                regs_q[w] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        rdata = '0;
        if ((state_q == S_WAIT || state_q == S_DATA) && !write_q) begin
            if (cur_idx == RO_IDX) begin
                rdata = status_in;
            end else begin
                for (int w = 0; w < RW_WORDS; w++) begin
                    if (w == int'(cur_idx)) begin
                        rdata = regs_q[w];
                    end
                end
            end
        end
    end

    assign bus.hrdata = rdata;
    assign bus.hready = hready_int;
    assign bus.hresp  = (state_q == S_ERR1) || (state_q == S_ERR2);

    for (genvar g = 0; g < RW_WORDS; g++) begin : g_ctrl
        assign ctrl_out[g*DW +: DW] = regs_q[g];
    end
endmodule
